// File: rtl/cim_arbiter.sv
// cim_arbiter: round-robin owner lock for one shared CIM crossbar tile.
// The owner keeps the tile for its whole transaction and releases it by
// dropping its request. If the tile is still busy when the owner lets go,
// the arbiter waits in DRAIN so that no new owner can take a busy tile.
module cim_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int IDX_WIDTH  = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req,
  output logic [NUM_REQ-1:0]            o_grant,
  input  logic [NUM_REQ-1:0]            i_req_cim_we,
  input  logic [NUM_REQ-1:0]            i_req_cim_start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_cim_ready,
  output logic                          o_cim_we,
  output logic                          o_cim_start,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  input  logic                          i_cim_ready,
  output logic [IDX_WIDTH-1:0]          o_owner,
  output logic                          o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;

  logic [IDX_WIDTH-1:0]   win, hi_idx, lo_idx;
  logic                   hi_found;
  logic                   own_req, own_we, own_start;
  logic [ADDR_WIDTH-1:0]  own_addr;

  // Select the current owner's request and CIM interface signals.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_start = 1'b0;
    own_addr  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IDX_WIDTH'(k)) begin
        own_req   = i_req[k];
        own_we    = i_req_cim_we[k];
        own_start = i_req_cim_start[k];
        own_addr  = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Round-robin pick: the lowest requester at or above the pointer, else
  // the lowest requester overall (the wrap). Scanning downward leaves the lowest.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (i_req[k]) begin
        lo_idx = IDX_WIDTH'(k);
        if (IDX_WIDTH'(k) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_WIDTH'(k);
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  // Next-state logic for the ownership FSM, grant vector and pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          state_d = S_GRANT;
          owner_d = win;
          grant_d = '0;
          for (int k = 0; k < NUM_REQ; k++)
            if (win == IDX_WIDTH'(k)) grant_d[k] = 1'b1;
          ptr_d = (win == IDX_WIDTH'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          grant_d = '0;
          state_d = i_cim_ready ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_cim_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, owner, grant and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // Route the owner to the tile only while it holds the grant. Outside GRANT
  // everything toward the tile and every ready bit is forced low.
  always_comb begin
    o_cim_we        = 1'b0;
    o_cim_start     = 1'b0;
    o_addr          = '0;
    o_req_cim_ready = '0;
    if (state_q == S_GRANT) begin
      o_cim_we    = own_we;
      o_cim_start = own_start;
      o_addr      = own_addr;
      for (int k = 0; k < NUM_REQ; k++)
        if (owner_q == IDX_WIDTH'(k)) o_req_cim_ready[k] = i_cim_ready;
    end
  end

  assign o_grant = grant_q;
  assign o_owner = owner_q;
  assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_cim_arbiter.sv
// tb_cim_arbiter: directed and random checks of cim_arbiter against a
// behavioural model of the ownership rules (4 requesters), plus a
// 3-requester instance for the pointer wrap.
module tb_cim_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0]  req, we, st, grant, rdyv;
  logic [15:0] addr;
  logic        rdy, cwe, cst, busy;
  logic [3:0]  caddr;
  logic [1:0]  owner;

  // 3-requester instance
  logic [2:0]  req3, we3, st3, grant3, rdyv3;
  logic [11:0] addr3;
  logic        rdy3, cwe3, cst3, busy3;
  logic [3:0]  caddr3;
  logic [1:0]  owner3;

  cim_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .i_req(req), .o_grant(grant),
    .i_req_cim_we(we), .i_req_cim_start(st), .i_req_addr(addr),
    .o_req_cim_ready(rdyv), .o_cim_we(cwe), .o_cim_start(cst),
    .o_addr(caddr), .i_cim_ready(rdy), .o_owner(owner), .o_busy(busy)
  );

  cim_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(4)) u3 (
    .clk(clk), .rst(rst), .i_req(req3), .o_grant(grant3),
    .i_req_cim_we(we3), .i_req_cim_start(st3), .i_req_addr(addr3),
    .o_req_cim_ready(rdyv3), .o_cim_we(cwe3), .o_cim_start(cst3),
    .o_addr(caddr3), .i_cim_ready(rdy3), .o_owner(owner3), .o_busy(busy3)
  );

  int    n_asrt = 0;
  int    n_fail = 0;
  string phase  = "init";

  // Model: mode 0 = no owner, 1 = owner holds tile, 2 = waiting for tile idle
  int m_mode, m_owner, m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      t = r >> ((p + i) % 4);
      if (t[0]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      t = g >> i;
      if (t[0]) return i;
    end
    return -1;
  endfunction

  task automatic check_all();
    logic [3:0]  eg, er, wv, sv;
    logic [15:0] av;
    eg = (m_mode == 1) ? (4'b0001 << m_owner) : 4'b0000;
    er = (m_mode == 1 && rdy) ? eg : 4'b0000;
    wv = we >> m_owner;
    sv = st >> m_owner;
    av = addr >> (m_owner * 4);
    check("grant", grant, eg);
    check("owner", owner, m_owner[1:0]);
    check("busy",  busy,  m_mode != 0);
    check("we",    cwe,   (m_mode == 1) ? wv[0] : 1'b0);
    check("start", cst,   (m_mode == 1) ? sv[0] : 1'b0);
    check("addr",  caddr, (m_mode == 1) ? av[3:0] : 4'h0);
    check("ready", rdyv,  er);
  endtask

  // One clock: model the transition from the inputs seen at the edge.
  task automatic tick();
    int nm, no, np;
    logic [3:0] t;
    nm = m_mode; no = m_owner; np = m_ptr;
    t  = req >> m_owner;
    case (m_mode)
      0: if (req != 4'b0) begin
           no = rr_pick(req, m_ptr);
           nm = 1;
           np = (no + 1) % 4;
         end
      1: if (!t[0]) nm = rdy ? 0 : 2;
      2: if (rdy) nm = 0;
      default: nm = 0;
    endcase
    @(posedge clk); #1;
    m_mode = nm; m_owner = no; m_ptr = np;
    check_all();
  endtask

  task automatic cyc3();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    req = '0; we = '0; st = '0; addr = '0; rdy = 1'b1;
    req3 = '0; we3 = '0; st3 = '0; addr3 = '0; rdy3 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    m_mode = 0; m_owner = 0; m_ptr = 0;
    #3;
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all();
  endtask

  int order[5];
  int gaps[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int ngr, held, idle_run;
  logic prev_busy;

  initial begin
    // Reset state
    phase = "reset";
    clear_inputs();
    do_reset();
    check("rst_grant", grant, 4'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst3_busy", busy3, 1'b0);

    // Single requester, one-cycle grant latency, combinational routing
    phase = "single";
    req = 4'b0100;
    tick();
    check("s_grant", grant, 4'b0100);
    check("s_owner", owner, 2'd2);
    addr = 16'h0A00; we = 4'b0100;
    #1;
    check("s_addr", caddr, 4'hA);
    check("s_we",   cwe,   1'b1);
    check_all();
    req = 4'b0;
    tick();
    tick();

    // Round robin with all requesters, 3-cycle ownerships
    phase = "rr";
    do_reset();
    req = 4'hF; rdy = 1'b1;
    ngr = 0; held = 0; idle_run = 0; prev_busy = 1'b0;
    for (int c = 0; c < 60 && ngr < 5; c++) begin
      tick();
      if (busy && !prev_busy) begin
        order[ngr] = oh_idx(grant);
        gaps[ngr]  = idle_run;
        ngr++;
        idle_run = 0;
      end
      if (!busy) idle_run++;
      prev_busy = busy;
      if (m_mode == 1) begin
        held++;
        if (held == 3) begin
          req  = 4'hF & ~(4'b0001 << m_owner);
          held = 0;
        end else req = 4'hF;
      end else req = 4'hF;
    end
    check("rr_count", ngr, 5);
    for (int i = 0; i < 5; i++) if (i < ngr) check("rr_order", order[i], exp_order[i]);
    for (int i = 1; i < 5; i++) if (i < ngr) check("rr_bubble", gaps[i], 1);

    // Release while the tile is busy
    phase = "drain";
    do_reset();
    req = 4'b0010; rdy = 1'b1;
    tick();
    check("d_grant", grant, 4'b0010);
    req = 4'b1010; rdy = 1'b0;
    tick();
    tick();
    req = 4'b1000;
    tick();
    check("d_grant0", grant, 4'b0);
    check("d_busy",   busy,  1'b1);
    req = 4'b1010;
    repeat (4) tick();
    check("d_hold", busy, 1'b1);
    rdy = 1'b1;
    tick();
    check("d_idle", busy, 1'b0);
    tick();
    check("d_next", grant, 4'b1000);
    check("d_own3", owner, 2'd3);
    req = 4'b0;
    tick();

    // Non-owner start and address must not reach the tile
    phase = "iso";
    do_reset();
    req = 4'b0001; rdy = 1'b1;
    tick();
    we = 4'b0; st = 4'b0100; addr = 16'h0703;
    #1;
    check("i_start", cst,   1'b0);
    check("i_addr",  caddr, 4'h3);
    check("i_ready", rdyv,  4'b0001);
    check_all();
    st = 4'b0101;
    #1;
    check("i_start0", cst, 1'b1);
    req = 4'b0;
    tick();

    // Non-power-of-2 pointer wrap
    phase = "np2";
    do_reset();
    req3 = 3'b010;
    cyc3();
    check("n_grant1", grant3, 3'b010);
    req3 = 3'b000;
    cyc3();
    check("n_idle", busy3, 1'b0);
    req3 = 3'b011;
    cyc3();
    check("n_wrap",  grant3, 3'b001);
    check("n_own0",  owner3, 2'd0);
    req3 = 3'b000;
    cyc3();
    req3 = 3'b011;
    cyc3();
    check("n_ptr1", grant3, 3'b010);
    req3 = 3'b000;
    cyc3();

    // Asynchronous reset in the middle of a grant
    phase = "areset";
    do_reset();
    req = 4'b0100; rdy = 1'b1;
    tick();
    we = 4'b0100; st = 4'b0100; addr = 16'h0500;
    #1;
    check_all();
    #2;
    rst = 1'b0;
    #1;
    check("a_grant", grant, 4'b0);
    check("a_busy",  busy,  1'b0);
    check("a_we",    cwe,   1'b0);
    check("a_start", cst,   1'b0);
    check("a_addr",  caddr, 4'h0);
    check("a_owner", owner, 2'd0);
    m_mode = 0; m_owner = 0; m_ptr = 0;
    req = 4'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    req = 4'b0010;
    tick();
    check("a_regrant", grant, 4'b0010);
    req = 4'b0;
    tick();

    // Random traffic against the model
    phase = "rand";
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) req = req ^ (4'b0001 << b);
      rdy  = ($urandom_range(0, 2) != 0);
      we   = 4'($urandom);
      st   = 4'($urandom);
      addr = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/cim_arbiter.md
Name: cim_arbiter

Overview:
- Shares one CIM crossbar tile between NUM_REQ layer controllers (conv/fc ctrl instances).
- Round-robin grant with ownership lock: the owner keeps the tile for its whole multi-bit-plane transaction (all ibuf consume/start/wait cycles) and releases by dropping its request.
- Sits between the layer controllers' CIM interface (we/start/addr/ready) and the CIM tile.
- Prevents a switch of owner while the CIM is busy.

Parameters:
- NUM_REQ, 4, number of requesting controllers (>=2)
- ADDR_WIDTH, 4, width of CIM/ibuf address
- IDX_WIDTH, (NUM_REQ<=2)?1:$clog2(NUM_REQ), width of owner index

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  NUM_REQ  per-requester ownership request (level)
- o_grant  out  NUM_REQ  one-hot grant, registered
- i_req_cim_we  in  NUM_REQ  per-requester CIM write enable
- i_req_cim_start  in  NUM_REQ  per-requester CIM start
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- o_req_cim_ready  out  NUM_REQ  per-requester view of CIM ready
- o_cim_we  out  1  to CIM
- o_cim_start  out  1  to CIM
- o_addr  out  ADDR_WIDTH  to CIM
- i_cim_ready  in  1  CIM idle/finished
- o_owner  out  IDX_WIDTH  current owner index, valid while o_busy=1
- o_busy  out  1  a grant is held (GRANT or DRAIN)

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; o_grant=0; o_owner=0; o_busy=0.
  - RR pointer=0; all CIM outputs 0; o_req_cim_ready=0.
- States:
  - IDLE
  - GRANT (owner active)
  - DRAIN (owner released while CIM busy)
- IDLE:
  - If any i_req bit is set, pick the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Next cycle: state=GRANT, o_grant=onehot(winner), o_owner=winner, pointer=(winner+1) mod NUM_REQ.
  - Grant latency: 1 cycle from request.
- GRANT:
  - o_cim_we, o_cim_start and o_addr are combinationally muxed from the owner's inputs.
  - o_req_cim_ready[owner]=i_cim_ready; every other bit is 0.
  - Requests from other requesters are ignored; no preemption.
- Release while in GRANT (i_req[owner]=0 sampled):
  - If i_cim_ready=1: next state IDLE.
  - Otherwise: next state DRAIN.
  - o_grant clears on that same edge in both cases.
- DRAIN:
  - CIM outputs forced to 0; all o_req_cim_ready=0; o_busy=1.
  - When i_cim_ready=1, go to IDLE.
  - The owner's i_req is ignored while in DRAIN.
- Turnaround and fairness:
  - IDLE always lasts at least 1 cycle between grants (1 bubble).
  - Back-to-back grants to the same requester happen only if no other request is pending.
- Outputs in IDLE: all CIM outputs 0; all o_req_cim_ready=0. A waiting controller therefore stays in its idle state until granted.
- Simultaneous events:
  - Owner release and new requests in the same cycle: the new requests arbitrate in IDLE on the following cycle, using the updated pointer.
  - i_cim_start from a non-owner is dropped, never forwarded.
- Reset mid-GRANT or mid-DRAIN: outputs return to reset values immediately (async); the pointer returns to 0.
- Width rules:
  - Owner index is IDX_WIDTH wide.
  - Pointer wraps modulo NUM_REQ, including non-power-of-2 NUM_REQ; indices >= NUM_REQ are never granted.

Test Plan:
- Single requester: i_req=4'b0100 at cycle 0 -> o_grant=4'b0100 and o_owner=2 at cycle 1. Owner addr=4'hA, we=1 -> o_addr=4'hA, o_cim_we=1 in the same cycle.
- Round robin: i_req=4'b1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0 with exactly 1 IDLE cycle between grants.
- Release while busy: owner 1 drops i_req while i_cim_ready=0 -> state DRAIN, o_grant=0, o_busy=1. i_cim_ready rises 5 cycles later -> IDLE next cycle, then req 3 granted.
- Isolation: owner 0 granted, requester 2 drives start=1 and addr=4'h7 -> o_cim_start follows requester 0 only. o_req_cim_ready=4'b0001 when i_cim_ready=1.
- Non-power-of-2: NUM_REQ=3, pointer at 2, i_req=3'b011 -> grant requester 0 (wrap), then the pointer becomes 1.
- Async reset: rst=0 mid-GRANT between clock edges -> o_grant=0, o_busy=0 and CIM outputs=0 before the next edge. After release, i_req=4'b0010 -> granted 1 cycle later.
